// File: rtl/chacha_stream_core.sv
// ChaCha keystream engine: configurable rounds, quarter-rounds per cycle and block count per command.
// Define CHACHA_IETF_EN for the RFC 8439 layout (32-bit counter, 96-bit nonce).
module chacha_stream_core #(
  parameter int unsigned ROUNDS       = 20,
  parameter int unsigned QR_PER_CYCLE = 4,
  parameter int unsigned NB_W         = 16,
`ifdef CHACHA_IETF_EN
  localparam int unsigned CW = 32,
  localparam int unsigned NW = 96
`else
  localparam int unsigned CW = 64,
  localparam int unsigned NW = 64
`endif
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [255:0]    cmd_key,
  input  logic [NW-1:0]   cmd_nonce,
  input  logic [CW-1:0]   cmd_counter,
  input  logic [NB_W-1:0] cmd_nblocks,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [511:0]    out_data,
  output logic [CW-1:0]   out_counter,
  output logic            done
);

  localparam int unsigned S  = 4 / QR_PER_CYCLE;
  localparam int unsigned HW = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;
  localparam logic [1:0]    SUB_LAST  = 2'(S - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(ROUNDS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  typedef logic [15:0][31:0] words_t;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic words_t init_state(input logic [255:0] key, input logic [NW-1:0] nonce,
                                        input logic [CW-1:0] ctr);
    words_t s;
    s[0] = 32'h61707865;
    s[1] = 32'h3320646e;
    s[2] = 32'h79622d32;
    s[3] = 32'h6b206574;
    for (int k = 0; k < 8; k++) s[4+k] = bswap32(key[255-32*k -: 32]);
`ifdef CHACHA_IETF_EN
    s[12] = ctr;
    for (int k = 0; k < 3; k++) s[13+k] = bswap32(nonce[95-32*k -: 32]);
`else
    s[12] = ctr[31:0];
    s[13] = ctr[63:32];
    s[14] = bswap32(nonce[63:32]);
    s[15] = bswap32(nonce[31:0]);
`endif
    return s;
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a_in, input logic [31:0] b_in,
                                      input logic [31:0] c_in, input logic [31:0] d_in);
    logic [31:0] a, b, c, d;
    a = a_in;
    b = b_in;
    c = c_in;
    d = d_in;
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  // One cycle of work: QR_PER_CYCLE of the four column/diagonal quarter-rounds, picked by sub.
  function automatic words_t round_step(input words_t x, input logic diag, input logic [1:0] sub);
    words_t       y;
    logic [1:0]   q;
    logic [3:0]   ia, ib, ic, id;
    logic [127:0] r;
    y = x;
    for (int j = 0; j < int'(QR_PER_CYCLE); j++) begin
      q  = 2'(sub * 2'(QR_PER_CYCLE) + 2'(j));
      ia = {2'b00, q};
      ib = {2'b01, 2'(q + (diag ? 2'd1 : 2'd0))};
      ic = {2'b10, 2'(q + (diag ? 2'd2 : 2'd0))};
      id = {2'b11, 2'(q + (diag ? 2'd3 : 2'd0))};
      r  = qr(y[ia], y[ib], y[ic], y[id]);
      y[ia] = r[127:96];
      y[ib] = r[95:64];
      y[ic] = r[63:32];
      y[id] = r[31:0];
    end
    return y;
  endfunction

  logic [1:0]      state_q, state_d;
  words_t          x_q, x_d;
  logic [255:0]    key_q, key_d;
  logic [NW-1:0]   nonce_q, nonce_d;
  logic [CW-1:0]   ctr_q, ctr_d;
  logic [NB_W-1:0] remaining_q, remaining_d;
  logic [HW-1:0]   half_q, half_d;
  logic [1:0]      sub_q, sub_d;
  logic [511:0]    out_data_q, out_data_d;
  logic [CW-1:0]   out_counter_q, out_counter_d;
  logic            done_q, done_d;

  words_t        x_rnd;
  words_t        init_w;
  logic [511:0]  keystream;
  logic [CW-1:0] ctr_inc;

  assign x_rnd   = round_step(x_q, half_q[0], sub_q);
  assign ctr_inc = ctr_q + 1'b1;

  always_comb begin
    init_w    = init_state(key_q, nonce_q, ctr_q);
    keystream = '0;
    for (int i = 0; i < 16; i++) keystream[511-32*i -: 32] = bswap32(x_q[i] + init_w[i]);
  end

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    key_d         = key_q;
    nonce_d       = nonce_q;
    ctr_d         = ctr_q;
    remaining_d   = remaining_q;
    half_d        = half_q;
    sub_d         = sub_q;
    out_data_d    = out_data_q;
    out_counter_d = out_counter_q;
    done_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          key_d       = cmd_key;
          nonce_d     = cmd_nonce;
          ctr_d       = cmd_counter;
          remaining_d = cmd_nblocks;
          if (cmd_nblocks == '0) begin
            done_d = 1'b1;
          end else begin
            x_d     = init_state(cmd_key, cmd_nonce, cmd_counter);
            half_d  = '0;
            sub_d   = '0;
            state_d = S_ROUND;
          end
        end
      end
      S_ROUND: begin
        x_d = x_rnd;
        if (sub_q == SUB_LAST) begin
          sub_d = '0;
          if (half_q == HALF_LAST) state_d = S_FINAL;
          else                     half_d  = half_q + 1'b1;
        end else begin
          sub_d = sub_q + 1'b1;
        end
      end
      S_FINAL: begin
        out_data_d    = keystream;
        out_counter_d = ctr_q;
        state_d       = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == NB_W'(1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ctr_d   = ctr_inc;
            x_d     = init_state(key_q, nonce_q, ctr_inc);
            half_d  = '0;
            sub_d   = '0;
            state_d = S_ROUND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      x_q           <= '0;
      key_q         <= '0;
      nonce_q       <= '0;
      ctr_q         <= '0;
      remaining_q   <= '0;
      half_q        <= '0;
      sub_q         <= '0;
      out_data_q    <= '0;
      out_counter_q <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      key_q         <= key_d;
      nonce_q       <= nonce_d;
      ctr_q         <= ctr_d;
      remaining_q   <= remaining_d;
      half_q        <= half_d;
      sub_q         <= sub_d;
      out_data_q    <= out_data_d;
      out_counter_q <= out_counter_d;
      done_q        <= done_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_HOLD);
  assign out_data    = out_data_q;
  assign out_counter = out_counter_q;
  assign done        = done_q;

endmodule

// File: tb/tb_chacha_stream_core.sv
// Bench for chacha_stream_core: directed sequence with random vectors checked against a word-level
// ChaCha model; extra instances with 2 and 1 quarter-rounds per cycle for latency/equivalence.
module tb_chacha_stream_core;
`ifdef CHACHA_IETF_EN
  localparam int CW = 32;
  localparam int NW = 96;
`else
  localparam int CW = 64;
  localparam int NW = 64;
`endif
  localparam int ROUNDS = 20;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [255:0]    cmd_key = '0;
  logic [NW-1:0]   cmd_nonce = '0;
  logic [CW-1:0]   cmd_counter = '0;
  logic [15:0]     cmd_nblocks = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [511:0]    out_data;
  logic [CW-1:0]   out_counter;
  logic            done;

  logic            alt_valid = 1'b0;
  logic            alt_ready = 1'b0;
  logic            rdy2, val2, done2, rdy1, val1, done1;
  logic [511:0]    data2, data1;
  logic [CW-1:0]   ctr2, ctr1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  chacha_stream_core dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_key(cmd_key), .cmd_nonce(cmd_nonce), .cmd_counter(cmd_counter),
    .cmd_nblocks(cmd_nblocks), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_counter(out_counter), .done(done)
  );

  chacha_stream_core #(.QR_PER_CYCLE(2)) dut_q2 (
    .clock(clock), .reset(reset), .cmd_valid(alt_valid), .cmd_ready(rdy2),
    .cmd_key(cmd_key), .cmd_nonce(cmd_nonce), .cmd_counter(cmd_counter),
    .cmd_nblocks(cmd_nblocks), .out_valid(val2), .out_ready(alt_ready),
    .out_data(data2), .out_counter(ctr2), .done(done2)
  );

  chacha_stream_core #(.QR_PER_CYCLE(1)) dut_q1 (
    .clock(clock), .reset(reset), .cmd_valid(alt_valid), .cmd_ready(rdy1),
    .cmd_key(cmd_key), .cmd_nonce(cmd_nonce), .cmd_counter(cmd_counter),
    .cmd_nblocks(cmd_nblocks), .out_valid(val1), .out_ready(alt_ready),
    .out_data(data1), .out_counter(ctr1), .done(done1)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain RFC-style double rounds on a word array.
  logic [31:0] mw [16];

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] le32(input logic [31:0] b);
    return {b[7:0], b[15:8], b[23:16], b[31:24]};
  endfunction

  task automatic mix(input int a, input int b, input int c, input int d);
    mw[a] += mw[b]; mw[d] = rotl(mw[d] ^ mw[a], 16);
    mw[c] += mw[d]; mw[b] = rotl(mw[b] ^ mw[c], 12);
    mw[a] += mw[b]; mw[d] = rotl(mw[d] ^ mw[a], 8);
    mw[c] += mw[d]; mw[b] = rotl(mw[b] ^ mw[c], 7);
  endtask

  task automatic model_block(input logic [255:0] key, input logic [NW-1:0] nonce,
                             input logic [CW-1:0] ctr, output logic [511:0] blk);
    logic [31:0] st0 [16];
    st0[0] = 32'h61707865;
    st0[1] = 32'h3320646e;
    st0[2] = 32'h79622d32;
    st0[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) st0[4+i] = le32(key[255-32*i -: 32]);
`ifdef CHACHA_IETF_EN
    st0[12] = ctr;
    for (int i = 0; i < 3; i++) st0[13+i] = le32(nonce[95-32*i -: 32]);
`else
    st0[12] = ctr[31:0];
    st0[13] = ctr[63:32];
    st0[14] = le32(nonce[63:32]);
    st0[15] = le32(nonce[31:0]);
`endif
    for (int i = 0; i < 16; i++) mw[i] = st0[i];
    for (int r = 0; r < ROUNDS / 2; r++) begin
      mix(0, 4, 8, 12); mix(1, 5, 9, 13); mix(2, 6, 10, 14); mix(3, 7, 11, 15);
      mix(0, 5, 10, 15); mix(1, 6, 11, 12); mix(2, 7, 8, 13); mix(3, 4, 9, 14);
    end
    blk = '0;
    for (int i = 0; i < 16; i++) blk[511-32*i -: 32] = le32(mw[i] + st0[i]);
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic issue(input logic [255:0] k, input logic [NW-1:0] n, input logic [CW-1:0] c,
                       input logic [15:0] nb);
    int w = 0;
    while (!cmd_ready && w < 200) begin
      @(posedge clock); #1; w++;
    end
    check("cmd_ready before issue", cmd_ready, 1'b1);
    cmd_key = k; cmd_nonce = n; cmd_counter = c; cmd_nblocks = nb;
    cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clock); #1; lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic run_blocks(input logic [255:0] k, input logic [NW-1:0] n, input logic [CW-1:0] c0,
                            input int nb, input int pct);
    int            got = 0;
    int            cyc = 0;
    int            dones = 0;
    logic          stalled = 1'b0;
    logic [511:0]  held, exp;
    logic [CW-1:0] c;
    while (got < nb && cyc < 2000) begin
      out_ready = ($urandom_range(99) < pct);
      if (done) dones++;
      if (out_valid) begin
        if (stalled) check("data stable while stalled", out_data, held);
        stalled = !out_ready;
        held    = out_data;
        if (out_ready) begin
          c = c0 + CW'(got);
          model_block(k, n, c, exp);
          check("block data", out_data, exp);
          check("block counter", out_counter, c);
          got++;
        end
      end else begin
        stalled = 1'b0;
      end
      @(posedge clock); #1; cyc++;
    end
    out_ready = 1'b0;
    check("blocks delivered", got, nb);
    check("no early done", dones, 0);
    check("done after last accept", done, 1'b1);
    check("cmd_ready on idle entry", cmd_ready, 1'b1);
    check("out_valid low in idle", out_valid, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " cmd_ready"}, cmd_ready, 1'b1);
    check({tag, " out_valid"}, out_valid, 1'b0);
    check({tag, " done"}, done, 1'b0);
    check({tag, " out_data"}, out_data, '0);
    check({tag, " out_counter"}, out_counter, '0);
  endtask

  initial begin
    logic [255:0]  k, tmp;
    logic [NW-1:0] n;
    logic [CW-1:0] c;
    logic [511:0]  exp;
    int            lat, lat2, lat1, bad;
    logic [511:0]  d2, d1;

    #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_reset_values("reset");
    reset = 1'b0;
    @(posedge clock); #1;

    // Zero key / nonce / counter reference vector
    issue('0, '0, '0, 16'd1);
    wait_valid(lat);
    check("latency qpc4", lat, 21);
    check("zero-key prefix", out_data[511:384], 128'h76b8e0ada0f13d90405d6ae55386bd28);
    run_blocks('0, '0, '0, 1, 100);
    @(posedge clock); #1;
    check("done single cycle", done, 1'b0);

`ifdef CHACHA_IETF_EN
    for (int i = 0; i < 32; i++) k[255-8*i -: 8] = 8'(i);
    n = 96'h000000090000004a00000000;
    issue(k, n, 32'd1, 16'd1);
    wait_valid(lat);
    check("rfc8439 prefix", out_data[511:384], 128'h10f1e7e4d13b5915500fdd1fa32071c4);
    run_blocks(k, n, 32'd1, 1, 100);
`endif

    // Four blocks with a randomly stalling consumer
    k = rand256(); tmp = rand256(); n = tmp[NW-1:0]; tmp = rand256(); c = tmp[CW-1:0];
    issue(k, n, c, 16'd4);
    run_blocks(k, n, c, 4, 30);

    // Counter wrap, issued in the done cycle of the previous command
    k = rand256(); tmp = rand256(); n = tmp[NW-1:0];
    issue(k, n, '1, 16'd2);
    run_blocks(k, n, '1, 2, 100);
    @(posedge clock); #1;

    // Zero-block command
    issue(k, n, '0, 16'd0);
    check("nblocks0 done", done, 1'b1);
    check("nblocks0 out_valid", out_valid, 1'b0);
    check("nblocks0 cmd_ready", cmd_ready, 1'b1);
    bad = 0;
    repeat (6) begin
      @(posedge clock); #1;
      if (out_valid || done) bad++;
    end
    check("nblocks0 quiet after", bad, 0);

    // Narrower datapaths must match the model and take 2x / 4x the round cycles
    k = rand256(); tmp = rand256(); n = tmp[NW-1:0]; tmp = rand256(); c = tmp[CW-1:0];
    check("alt idle qpc2", rdy2, 1'b1);
    check("alt idle qpc1", rdy1, 1'b1);
    cmd_key = k; cmd_nonce = n; cmd_counter = c; cmd_nblocks = 16'd1;
    alt_valid = 1'b1;
    @(posedge clock); #1;
    alt_valid = 1'b0;
    alt_ready = 1'b1;
    lat2 = -1; lat1 = -1; d2 = '0; d1 = '0;
    for (int cyc = 1; cyc <= 120; cyc++) begin
      @(posedge clock); #1;
      if (val2 && lat2 < 0) begin lat2 = cyc; d2 = data2; end
      if (val1 && lat1 < 0) begin lat1 = cyc; d1 = data1; end
    end
    alt_ready = 1'b0;
    model_block(k, n, c, exp);
    check("latency qpc2", lat2, 41);
    check("latency qpc1", lat1, 81);
    check("data qpc2", d2, exp);
    check("data qpc1", d1, exp);

    // Reset in the middle of the rounds
    k = rand256(); tmp = rand256(); n = tmp[NW-1:0]; tmp = rand256(); c = tmp[CW-1:0];
    issue(k, n, c, 16'd3);
    repeat (5) @(posedge clock);
    #2 reset = 1'b1;
    #1 check_reset_values("reset mid-round");
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Reset while a block is held
    issue(k, n, c, 16'd2);
    wait_valid(lat);
    check("latency before hold reset", lat, 21);
    #2 reset = 1'b1;
    #1 check_reset_values("reset in hold");
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Recovery behaves as the first vector
    issue('0, '0, '0, 16'd1);
    wait_valid(lat);
    check("latency after reset", lat, 21);
    check("zero-key prefix after reset", out_data[511:384],
          128'h76b8e0ada0f13d90405d6ae55386bd28);
    run_blocks('0, '0, '0, 1, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
